// File: rtl/alu_ctl.sv
// Issue/sequencing front-end for the 64-bit ALU: synthesises OR/SUB/SLT/SLTU/W ops from ALU primitives.
// Latency accept->rsp_valid_o: 2 cycles ordinary, 3 for SLT/SLTU, 1 for illegal op/W combinations.
// Backpressure: one transaction in flight; req_ready_o only in IDLE, DONE holds the response until rsp_ready_i.
module alu_ctl #(
    parameter int XLEN = 64
) (
    input  logic            clk_i,
    input  logic            reset_ni,
    input  logic            req_valid_i,
    output logic            req_ready_o,
    input  logic [3:0]      req_op_i,
    input  logic            req_w_i,
    input  logic [XLEN-1:0] req_a_i,
    input  logic [XLEN-1:0] req_b_i,
    output logic            rsp_valid_o,
    input  logic            rsp_ready_i,
    output logic [XLEN-1:0] rsp_data_o,
    output logic            rsp_err_o,
    output logic [XLEN-1:0] alu_a_o,
    output logic [XLEN-1:0] alu_b_o,
    output logic            alu_cflag_o,
    output logic            alu_sum_en_o,
    output logic            alu_and_en_o,
    output logic            alu_xor_en_o,
    output logic            alu_invb_en_o,
    output logic            alu_lsh_en_o,
    output logic            alu_rsh_en_o,
    input  logic [XLEN-1:0] alu_out_i,
    input  logic            alu_c_i,
    input  logic            alu_v_i,
    input  logic            alu_z_i
);

    localparam logic [3:0] OP_ADD  = 4'd0;
    localparam logic [3:0] OP_SUB  = 4'd1;
    localparam logic [3:0] OP_AND  = 4'd2;
    localparam logic [3:0] OP_OR   = 4'd3;
    localparam logic [3:0] OP_XOR  = 4'd4;
    localparam logic [3:0] OP_SLL  = 4'd5;
    localparam logic [3:0] OP_SRL  = 4'd6;
    localparam logic [3:0] OP_SRA  = 4'd7;
    localparam logic [3:0] OP_SLT  = 4'd8;
    localparam logic [3:0] OP_SLTU = 4'd9;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        FLAG = 2'd2,
        DONE = 2'd3
    } state_e;

    typedef struct packed {
        logic [3:0]      op;
        logic            w;
        logic [XLEN-1:0] a;
        logic [XLEN-1:0] b;
    } req_t;

    state_e          state_q, state_d;
    req_t            req_q;
    req_t            req_in;
    logic [XLEN-1:0] res_q;
    logic            err_q;
    logic            c_q;
    logic            v_q;
    logic            req_illegal;
    logic            is_cmp;
    logic            lt;
    logic [XLEN-1:0] sh_b;
    logic [XLEN-1:0] exec_res;

    // No synthesised op needs the zero flag.
    logic unused_z;
    assign unused_z = alu_z_i;

    assign req_in = '{op: req_op_i, w: req_w_i, a: req_a_i, b: req_b_i};

    always_comb begin
        req_illegal = 1'b0;
        if (req_op_i > OP_SLTU) begin
            req_illegal = 1'b1;
        end else if (req_w_i) begin
            case (req_op_i)
                OP_ADD, OP_SUB, OP_SLL, OP_SRL, OP_SRA: req_illegal = 1'b0;
                default:                                req_illegal = 1'b1;
            endcase
        end
    end

    assign is_cmp = (req_q.op == OP_SLT) || (req_q.op == OP_SLTU);

    // Compare result derives from the subtraction captured in EXEC.
    assign lt = (req_q.op == OP_SLT) ? (res_q[XLEN-1] ^ v_q) : ~c_q;

    assign sh_b = req_q.w ? {{(XLEN-5){1'b0}}, req_q.b[4:0]}
                          : {{(XLEN-6){1'b0}}, req_q.b[5:0]};

    assign exec_res = req_q.w ? {{(XLEN-32){alu_out_i[31]}}, alu_out_i[31:0]} : alu_out_i;

    always_comb begin
        state_d     = state_q;
        req_ready_o = 1'b0;
        rsp_valid_o = 1'b0;
        case (state_q)
            IDLE: begin
                req_ready_o = 1'b1;
                if (req_valid_i) begin
                    state_d = req_illegal ? DONE : EXEC;
                end
            end
            EXEC: state_d = is_cmp ? FLAG : DONE;
            FLAG: state_d = DONE;
            DONE: begin
                rsp_valid_o = 1'b1;
                if (rsp_ready_i) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        alu_a_o       = '0;
        alu_b_o       = '0;
        alu_cflag_o   = 1'b0;
        alu_sum_en_o  = 1'b0;
        alu_and_en_o  = 1'b0;
        alu_xor_en_o  = 1'b0;
        alu_invb_en_o = 1'b0;
        alu_lsh_en_o  = 1'b0;
        alu_rsh_en_o  = 1'b0;
        if (state_q == EXEC) begin
            alu_a_o = req_q.a;
            alu_b_o = req_q.b;
            case (req_q.op)
                OP_ADD: alu_sum_en_o = 1'b1;
                OP_SUB, OP_SLT, OP_SLTU: begin
                    alu_sum_en_o  = 1'b1;
                    alu_invb_en_o = 1'b1;
                    alu_cflag_o   = 1'b1;
                end
                OP_AND: alu_and_en_o = 1'b1;
                // (A&B)|(A^B) == A|B when the ALU merges enabled functions.
                OP_OR: begin
                    alu_and_en_o = 1'b1;
                    alu_xor_en_o = 1'b1;
                end
                OP_XOR: alu_xor_en_o = 1'b1;
                OP_SLL: begin
                    alu_lsh_en_o = 1'b1;
                    alu_b_o      = sh_b;
                end
                OP_SRL: begin
                    alu_rsh_en_o = 1'b1;
                    if (req_q.w) begin
                        alu_a_o = {{(XLEN-32){1'b0}}, req_q.a[31:0]};
                        alu_b_o = sh_b;
                    end
                end
                OP_SRA: begin
                    alu_rsh_en_o = 1'b1;
                    alu_cflag_o  = 1'b1;
                    if (req_q.w) begin
                        alu_a_o = {{(XLEN-32){req_q.a[31]}}, req_q.a[31:0]};
                        alu_b_o = sh_b;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            state_q <= IDLE;
            req_q   <= '0;
            res_q   <= '0;
            err_q   <= 1'b0;
            c_q     <= 1'b0;
            v_q     <= 1'b0;
        end else begin
            state_q <= state_d;
            case (state_q)
                IDLE: begin
                    if (req_valid_i) begin
                        req_q <= req_in;
                        res_q <= '0;
                        err_q <= req_illegal;
                    end
                end
                EXEC: begin
                    res_q <= exec_res;
                    c_q   <= alu_c_i;
                    v_q   <= alu_v_i;
                end
                FLAG:    res_q <= {{(XLEN-1){1'b0}}, lt};
                default: ;
            endcase
        end
    end

    assign rsp_data_o = res_q;
    assign rsp_err_o  = err_q;

endmodule

// File: tb/tb_alu_ctl.sv
// Directed bench for alu_ctl with a behavioural 64-bit ALU closing the loop.
module tb_alu_ctl;

    logic        clk_i = 1'b0;
    logic        reset_ni = 1'b0;
    logic        req_valid_i = 1'b0;
    logic        req_ready_o;
    logic [3:0]  req_op_i = 4'd0;
    logic        req_w_i = 1'b0;
    logic [63:0] req_a_i = 64'd0;
    logic [63:0] req_b_i = 64'd0;
    logic        rsp_valid_o;
    logic        rsp_ready_i = 1'b0;
    logic [63:0] rsp_data_o;
    logic        rsp_err_o;
    logic [63:0] alu_a_o, alu_b_o;
    logic        alu_cflag_o, alu_sum_en_o, alu_and_en_o, alu_xor_en_o;
    logic        alu_invb_en_o, alu_lsh_en_o, alu_rsh_en_o;
    logic [63:0] alu_out_i;
    logic        alu_c_i, alu_v_i, alu_z_i;

    int n_checks = 0;
    int n_fail   = 0;

    alu_ctl #(.XLEN(64)) dut (
        .clk_i(clk_i), .reset_ni(reset_ni),
        .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
        .req_op_i(req_op_i), .req_w_i(req_w_i), .req_a_i(req_a_i), .req_b_i(req_b_i),
        .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i),
        .rsp_data_o(rsp_data_o), .rsp_err_o(rsp_err_o),
        .alu_a_o(alu_a_o), .alu_b_o(alu_b_o), .alu_cflag_o(alu_cflag_o),
        .alu_sum_en_o(alu_sum_en_o), .alu_and_en_o(alu_and_en_o), .alu_xor_en_o(alu_xor_en_o),
        .alu_invb_en_o(alu_invb_en_o), .alu_lsh_en_o(alu_lsh_en_o), .alu_rsh_en_o(alu_rsh_en_o),
        .alu_out_i(alu_out_i), .alu_c_i(alu_c_i), .alu_v_i(alu_v_i), .alu_z_i(alu_z_i)
    );

    always #5 clk_i = ~clk_i;

    // Behavioural ALU: enabled function outputs are ORed together.
    logic [63:0] m_b;
    logic [64:0] m_sum;
    always_comb begin
        m_b   = alu_invb_en_o ? ~alu_b_o : alu_b_o;
        m_sum = {1'b0, alu_a_o} + {1'b0, m_b} + {64'd0, alu_cflag_o};
        alu_out_i = 64'd0;
        if (alu_sum_en_o) alu_out_i = alu_out_i | m_sum[63:0];
        if (alu_and_en_o) alu_out_i = alu_out_i | (alu_a_o & m_b);
        if (alu_xor_en_o) alu_out_i = alu_out_i | (alu_a_o ^ m_b);
        if (alu_lsh_en_o) alu_out_i = alu_out_i | (alu_a_o << alu_b_o[5:0]);
        if (alu_rsh_en_o) alu_out_i = alu_out_i | (alu_cflag_o ? 64'($signed(alu_a_o) >>> alu_b_o[5:0])
                                                               : (alu_a_o >> alu_b_o[5:0]));
        alu_c_i = alu_sum_en_o & m_sum[64];
        alu_v_i = alu_sum_en_o & (alu_a_o[63] == m_b[63]) & (m_sum[63] != alu_a_o[63]);
        alu_z_i = (alu_out_i == 64'd0);
    end

    task automatic issue(input logic [3:0] op, input logic w, input logic [63:0] a, input logic [63:0] b,
                         output int lat, output logic [63:0] data, output logic err);
        req_op_i = op; req_w_i = w; req_a_i = a; req_b_i = b; req_valid_i = 1'b1;
        @(posedge clk_i); #1;
        req_valid_i = 1'b0;
        lat = 1;
        while (!rsp_valid_o && lat < 20) begin
            @(posedge clk_i); #1;
            lat++;
        end
        if (!rsp_valid_o) lat = -1;
        data = rsp_data_o;
        err  = rsp_err_o;
    endtask

    task automatic drain();
        rsp_ready_i = 1'b1;
        @(posedge clk_i); #1;
        rsp_ready_i = 1'b0;
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clk_i);
        #1;
        n_checks++; if (req_ready_o !== 1'b1) begin n_fail++; $display("FAIL rst_ready: got %b want 1", req_ready_o); end
        reset_ni = 1'b1;
        @(posedge clk_i); #1;
        n_checks++; if (req_ready_o !== 1'b1) begin n_fail++; $display("FAIL rel_ready: got %b want 1", req_ready_o); end
        n_checks++; if (rsp_valid_o !== 1'b0) begin n_fail++; $display("FAIL rel_valid: got %b want 0", rsp_valid_o); end
        n_checks++; if (rsp_data_o !== 64'd0 || rsp_err_o !== 1'b0) begin n_fail++; $display("FAIL rel_rsp: got %h/%b want 0/0", rsp_data_o, rsp_err_o); end
        n_checks++; if ({alu_sum_en_o, alu_and_en_o, alu_xor_en_o, alu_invb_en_o, alu_lsh_en_o, alu_rsh_en_o, alu_cflag_o} !== 7'd0 || alu_a_o !== 64'd0 || alu_b_o !== 64'd0) begin
            n_fail++; $display("FAIL rel_alu: ALU controls not zero in IDLE"); end
    endtask

    task automatic test_add_or();
        int lat; logic [63:0] d; logic e;
        issue(4'd0, 1'b0, 64'd5, 64'd7, lat, d, e);
        n_checks++; if (lat !== 2) begin n_fail++; $display("FAIL add_lat: got %0d want 2", lat); end
        n_checks++; if (d !== 64'd12 || e !== 1'b0) begin n_fail++; $display("FAIL add_data: got %h/%b want 12/0", d, e); end
        drain();
        n_checks++; if (req_ready_o !== 1'b1 || rsp_valid_o !== 1'b0) begin n_fail++; $display("FAIL add_drain: ready %b valid %b", req_ready_o, rsp_valid_o); end
        // OR is checked by hand to observe the ALU controls in EXEC.
        req_op_i = 4'd3; req_w_i = 1'b0; req_a_i = 64'hF0; req_b_i = 64'h0F; req_valid_i = 1'b1;
        @(posedge clk_i); #1;
        req_valid_i = 1'b0;
        n_checks++; if ({alu_and_en_o, alu_xor_en_o, alu_sum_en_o, alu_invb_en_o} !== 4'b1100 || req_ready_o !== 1'b0) begin
            n_fail++; $display("FAIL or_ctl: and/xor/sum/invb %b%b%b%b ready %b want 1100 0", alu_and_en_o, alu_xor_en_o, alu_sum_en_o, alu_invb_en_o, req_ready_o); end
        @(posedge clk_i); #1;
        n_checks++; if (rsp_valid_o !== 1'b1 || rsp_data_o !== 64'hFF) begin n_fail++; $display("FAIL or_data: valid %b data %h want 1 ff", rsp_valid_o, rsp_data_o); end
        drain();
    endtask

    task automatic test_sub_cmp();
        int lat; logic [63:0] d; logic e;
        issue(4'd1, 1'b0, 64'd0, 64'd1, lat, d, e);
        n_checks++; if (d !== 64'hFFFF_FFFF_FFFF_FFFF || lat !== 2) begin n_fail++; $display("FAIL sub: got %h lat %0d want ffffffffffffffff lat 2", d, lat); end
        drain();
        issue(4'd8, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, lat, d, e);
        n_checks++; if (d !== 64'd1) begin n_fail++; $display("FAIL slt_neg: got %h want 1", d); end
        n_checks++; if (lat !== 3) begin n_fail++; $display("FAIL slt_lat: got %0d want 3", lat); end
        drain();
        issue(4'd9, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, lat, d, e);
        n_checks++; if (d !== 64'd0) begin n_fail++; $display("FAIL sltu: got %h want 0", d); end
        n_checks++; if (lat !== 3) begin n_fail++; $display("FAIL sltu_lat: got %0d want 3", lat); end
        drain();
        issue(4'd8, 1'b0, 64'h8000_0000_0000_0000, 64'd1, lat, d, e);
        n_checks++; if (d !== 64'd1) begin n_fail++; $display("FAIL slt_ovf: got %h want 1", d); end
        drain();
    endtask

    task automatic test_shift_w();
        int lat; logic [63:0] d; logic e;
        issue(4'd7, 1'b0, 64'h8000_0000_0000_0000, 64'd63, lat, d, e);
        n_checks++; if (d !== 64'hFFFF_FFFF_FFFF_FFFF) begin n_fail++; $display("FAIL sra: got %h want ffffffffffffffff", d); end
        drain();
        issue(4'd7, 1'b1, 64'h0000_0000_8000_0000, 64'h21, lat, d, e);
        n_checks++; if (d !== 64'hFFFF_FFFF_C000_0000 || e !== 1'b0) begin n_fail++; $display("FAIL sraw: got %h/%b want ffffffffc0000000/0", d, e); end
        drain();
        issue(4'd6, 1'b1, 64'h0000_0000_8000_0000, 64'h21, lat, d, e);
        n_checks++; if (d !== 64'h0000_0000_4000_0000) begin n_fail++; $display("FAIL srlw: got %h want 0000000040000000", d); end
        drain();
        issue(4'd0, 1'b1, 64'h7FFF_FFFF, 64'd1, lat, d, e);
        n_checks++; if (d !== 64'hFFFF_FFFF_8000_0000 || lat !== 2) begin n_fail++; $display("FAIL addw: got %h lat %0d want ffffffff80000000 lat 2", d, lat); end
        drain();
        issue(4'd5, 1'b0, 64'd1, 64'h43, lat, d, e);
        n_checks++; if (d !== 64'd8) begin n_fail++; $display("FAIL sll_mask: got %h want 8", d); end
        drain();
    endtask

    task automatic test_illegal();
        int lat; logic [63:0] d; logic e;
        issue(4'd12, 1'b0, 64'd3, 64'd4, lat, d, e);
        n_checks++; if (e !== 1'b1 || d !== 64'd0) begin n_fail++; $display("FAIL ill_op: got %h/%b want 0/1", d, e); end
        n_checks++; if (lat !== 1) begin n_fail++; $display("FAIL ill_op_lat: got %0d want 1", lat); end
        drain();
        issue(4'd2, 1'b1, 64'hFF, 64'hFF, lat, d, e);
        n_checks++; if (e !== 1'b1 || d !== 64'd0 || lat !== 1) begin n_fail++; $display("FAIL ill_andw: got %h/%b lat %0d want 0/1 lat 1", d, e, lat); end
        drain();
        issue(4'd2, 1'b0, 64'hFF, 64'h3C, lat, d, e);
        n_checks++; if (e !== 1'b0 || d !== 64'h3C) begin n_fail++; $display("FAIL and_after_err: got %h/%b want 3c/0", d, e); end
        drain();
    endtask

    task automatic test_backpressure();
        int lat; logic [63:0] d; logic e;
        issue(4'd4, 1'b0, 64'hFF00, 64'h0FF0, lat, d, e);
        n_checks++; if (d !== 64'hF0F0) begin n_fail++; $display("FAIL xor: got %h want f0f0", d); end
        for (int i = 0; i < 5; i++) begin
            @(posedge clk_i); #1;
            n_checks++;
            if (rsp_valid_o !== 1'b1 || rsp_data_o !== 64'hF0F0 || req_ready_o !== 1'b0) begin
                n_fail++; $display("FAIL bp_hold%0d: valid %b data %h ready %b want 1 f0f0 0", i, rsp_valid_o, rsp_data_o, req_ready_o); end
        end
        drain();
    endtask

    task automatic test_reset_mid();
        req_op_i = 4'd0; req_w_i = 1'b0; req_a_i = 64'd1; req_b_i = 64'd2; req_valid_i = 1'b1;
        @(posedge clk_i); #1;
        req_valid_i = 1'b0;
        n_checks++; if (alu_sum_en_o !== 1'b1 || alu_a_o !== 64'd1) begin n_fail++; $display("FAIL mid_exec: sum_en %b a %h want 1 1", alu_sum_en_o, alu_a_o); end
        reset_ni = 1'b0;
        #1;
        n_checks++; if (req_ready_o !== 1'b1 || rsp_valid_o !== 1'b0 || rsp_data_o !== 64'd0) begin
            n_fail++; $display("FAIL mid_rst: ready %b valid %b data %h want 1 0 0", req_ready_o, rsp_valid_o, rsp_data_o); end
        n_checks++; if (alu_sum_en_o !== 1'b0 || alu_a_o !== 64'd0 || alu_b_o !== 64'd0) begin n_fail++; $display("FAIL mid_rst_alu: sum_en %b a %h", alu_sum_en_o, alu_a_o); end
        @(posedge clk_i); #1;
        reset_ni = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk_i); #1;
            n_checks++;
            if (rsp_valid_o !== 1'b0 || req_ready_o !== 1'b1) begin n_fail++; $display("FAIL stray%0d: valid %b ready %b want 0 1", i, rsp_valid_o, req_ready_o); end
        end
    endtask

    initial begin
        test_reset();
        test_add_or();
        test_sub_cmp();
        test_shift_w();
        test_illegal();
        test_backpressure();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, %0d checks done", n_checks);
        $fatal(1, "watchdog expired");
    end

endmodule
